// File: rtl/leds_pattern_if.sv
// Control/display bundle for leds_pattern: pattern source, mode select, step pulse and LED drive.
// The duty input exists only when LEDS_PWM_EN is defined.
interface leds_pattern_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       mode;
    logic [WIDTH-1:0] pattern;
    logic             load;
`ifdef LEDS_PWM_EN
    logic [3:0]       duty;
`endif
    logic             step;
    logic [WIDTH-1:0] LPORT;

`ifdef LEDS_PWM_EN
    modport master (output mode, output pattern, output load, output duty,
                    input step, input LPORT);
    modport slave  (input mode, input pattern, input load, input duty,
                    output step, output LPORT);
`else
    modport master (output mode, output pattern, output load,
                    input step, input LPORT);
    modport slave  (input mode, input pattern, input load,
                    output step, output LPORT);
`endif
endinterface

// File: rtl/leds_pattern.sv
// LED pattern generator: static / blink / rotate-left / bounce on a DIV-cycle prescaler.
// Optional LEDS_PWM_EN adds a 16-step duty gate on the LED drive.
module leds_pattern #(
    parameter int               WIDTH = 8,
    parameter int               DIV   = 12000000,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          rstn,
    leds_pattern_if.slave bus
);
    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        M_STATIC = 2'd0,
        M_BLINK  = 2'd1,
        M_ROTATE = 2'd2,
        M_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] state_q, state_d;
    dir_e             dir_q, dir_d;
    logic             phase_q, phase_d;
    mode_e            mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             step_q, step_d;
    logic [WIDTH-1:0] lport_q, lport_d;
    logic [WIDTH-1:0] base;
    logic             restart;
    logic             lit;
`ifdef LEDS_PWM_EN
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q   <= INIT;
            state_q <= INIT;
            dir_q   <= DIR_LEFT;
            phase_q <= 1'b1;
            mode_q  <= M_STATIC;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            lport_q <= '0;
        end else begin
            pat_q   <= pat_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            lport_q <= lport_d;
        end
    end

`ifdef LEDS_PWM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_d;
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        lit       = (pwm_cnt_q < bus.duty);
    end
`else
    always_comb lit = 1'b1;
`endif

    always_comb begin
        pat_d   = pat_q;
        state_d = state_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q + 1'b1;
        step_d  = 1'b0;
        restart = bus.load || (bus.mode != mode_q);

        // A restart swallows any step due this cycle and re-arms the prescaler.
        if (restart) begin
            mode_d  = mode_e'(bus.mode);
            dir_d   = DIR_LEFT;
            phase_d = 1'b1;
            cnt_d   = '0;
            if (bus.load) begin
                pat_d   = bus.pattern;
                state_d = bus.pattern;
            end else begin
                state_d = pat_q;
            end
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            step_d = 1'b1;
            case (mode_q)
                M_BLINK:  phase_d = ~phase_q;
                M_ROTATE: state_d = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
                M_BOUNCE: begin
                    if (dir_q == DIR_LEFT) begin
                        if (state_q[WIDTH-1]) begin
                            dir_d   = DIR_RIGHT;
                            state_d = state_q >> 1;
                        end else begin
                            state_d = state_q << 1;
                        end
                    end else begin
                        if (state_q[0]) begin
                            dir_d   = DIR_LEFT;
                            state_d = state_q << 1;
                        end else begin
                            state_d = state_q >> 1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Drive from next-state values so step and the LED change share an edge.
        base    = (mode_d == M_BLINK && !phase_d) ? '0 : state_d;
        lport_d = base & {WIDTH{lit}};
    end

    assign bus.step  = step_q;
    assign bus.LPORT = lport_q;
endmodule
